// File: rtl/key_cmd_gen_pkg.sv
// Shared keycodes, command and FSM state types for the keyboard command path.
// Optional hold key is enabled with `define KEY_HOLD_EN.
package tetris_pkg;

    localparam logic [7:0] KEY_NONE   = 8'h00;
    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_DOWN   = 8'h16;
    localparam logic [7:0] KEY_ROTATE = 8'h1A;
    localparam logic [7:0] KEY_DROP   = 8'h2C;
    localparam logic [7:0] KEY_HOLD   = 8'h06;

    typedef enum logic [2:0] {
        CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_ROTATE, CMD_DROP, CMD_HOLD
    } cmd_e;

    typedef enum logic [1:0] {IDLE, SHOT, DAS, REPEAT} kstate_e;

    // Unrecognised keycodes decode to CMD_NONE, so they behave exactly like 0x00.
    function automatic cmd_e decode_key(input logic [7:0] kc);
        cmd_e c;
        case (kc)
            KEY_LEFT:   c = CMD_LEFT;
            KEY_RIGHT:  c = CMD_RIGHT;
            KEY_DOWN:   c = CMD_DOWN;
            KEY_ROTATE: c = CMD_ROTATE;
            KEY_DROP:   c = CMD_DROP;
`ifdef KEY_HOLD_EN
            KEY_HOLD:   c = CMD_HOLD;
`endif
            default:    c = CMD_NONE;
        endcase
        return c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_cmd_gen_if.sv
// Keycode in, command pulses out. The keycode is a level sampled every frame;
// cmd_* are single-frame pulses and key_active is a level. No backpressure exists.
interface key_cmd_gen_if;
    import tetris_pkg::*;

    logic [7:0] keycode;
    logic       cmd_left;
    logic       cmd_right;
    logic       cmd_down;
    logic       cmd_rotate;
    logic       cmd_drop;
`ifdef KEY_HOLD_EN
    logic       cmd_hold;
`endif
    logic       key_active;
    kstate_e    dbg_state;

    modport master (
        output keycode,
`ifdef KEY_HOLD_EN
        input  cmd_hold,
`endif
        input  cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop,
        input  key_active, dbg_state
    );

    modport slave (
        input  keycode,
`ifdef KEY_HOLD_EN
        output cmd_hold,
`endif
        output cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop,
        output key_active, dbg_state
    );

endinterface

// File: rtl/key_cmd_gen_repeat_timer.sv
// Frame counter for DAS/ARR/soft-drop timing; tick fires when the running count
// reaches the period, and the count restarts at 1 on that tick so it never wraps.
module repeat_timer #(
    parameter int CW = 5
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          clear,
    input  logic          load,
    input  logic          run,
    input  logic [CW-1:0] period,
    output logic          tick
);

    logic [CW-1:0] count;

    assign tick = run && (count >= period);

    always_ff @(posedge frame_clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (run) begin
            count <= tick ? CW'(1) : count + CW'(1);
        end
    end

endmodule

// File: rtl/key_cmd_gen.sv
// Keycode to one-frame command pulses with edge detect, DAS and auto-repeat.
// Define KEY_HOLD_EN to recognise 0x06 and drive cmd_hold.
module key_cmd_gen
    import tetris_pkg::*;
#(
    parameter int DAS_FRAMES   = 10,
    parameter int ARR_FRAMES   = 3,
    parameter int SDROP_FRAMES = 2
) (
    input logic           frame_clk,
    input logic           Reset,
    key_cmd_gen_if.slave  kif
);

    localparam int CW = $clog2(max3(DAS_FRAMES, ARR_FRAMES, SDROP_FRAMES)) + 1;

    kstate_e       state;
    logic [7:0]    cur_key;
    cmd_e          cmd_q;
    logic          active_q;

    cmd_e          new_cmd;
    cmd_e          cur_cmd;
    logic          same_hold;
    logic          is_lr;
    logic          is_down;
    logic [CW-1:0] period;
    logic          tick;

    always_comb begin
        new_cmd   = decode_key(kif.keycode);
        cur_cmd   = decode_key(cur_key);
        same_hold = (state != IDLE) && (new_cmd != CMD_NONE) && (kif.keycode == cur_key);
        is_lr     = (cur_cmd == CMD_LEFT) || (cur_cmd == CMD_RIGHT);
        is_down   = (cur_cmd == CMD_DOWN);
        // Left/right wait out DAS until the first repeat, then use ARR.
        if (is_down)
            period = CW'(SDROP_FRAMES);
        else if (state == REPEAT)
            period = CW'(ARR_FRAMES);
        else
            period = CW'(DAS_FRAMES);
    end

    repeat_timer #(.CW(CW)) u_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (new_cmd == CMD_NONE),
        .load      ((new_cmd != CMD_NONE) && !same_hold),
        .run       (same_hold && (is_lr || is_down)),
        .period    (period),
        .tick      (tick)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= IDLE;
            cur_key  <= KEY_NONE;
            cmd_q    <= CMD_NONE;
            active_q <= 1'b0;
        end else begin
            cmd_q <= CMD_NONE;
            if (new_cmd == CMD_NONE) begin
                state    <= IDLE;
                cur_key  <= KEY_NONE;
                active_q <= 1'b0;
            end else if (!same_hold) begin
                // Fresh press or a switch to another key: restart with an immediate pulse.
                state    <= SHOT;
                cur_key  <= kif.keycode;
                cmd_q    <= new_cmd;
                active_q <= 1'b1;
            end else begin
                active_q <= 1'b1;
                case (state)
                    SHOT: begin
                        if (is_lr) begin
                            if (tick) begin
                                cmd_q <= cur_cmd;
                                state <= REPEAT;
                            end else begin
                                state <= DAS;
                            end
                        end else if (is_down) begin
                            if (tick) cmd_q <= cur_cmd;
                            state <= REPEAT;
                        end
                    end
                    DAS: begin
                        if (tick) begin
                            cmd_q <= cur_cmd;
                            state <= REPEAT;
                        end
                    end
                    REPEAT: begin
                        if (tick) cmd_q <= cur_cmd;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kif.cmd_left   = (cmd_q == CMD_LEFT);
    assign kif.cmd_right  = (cmd_q == CMD_RIGHT);
    assign kif.cmd_down   = (cmd_q == CMD_DOWN);
    assign kif.cmd_rotate = (cmd_q == CMD_ROTATE);
    assign kif.cmd_drop   = (cmd_q == CMD_DROP);
`ifdef KEY_HOLD_EN
    assign kif.cmd_hold   = (cmd_q == CMD_HOLD);
`endif
    assign kif.key_active = active_q;
    assign kif.dbg_state  = state;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Bench for key_cmd_gen: directed scenarios plus random key sequences, checked
// against a frame-arithmetic model of when each held key should pulse.
module tb_key_cmd_gen;
    import tetris_pkg::*;

    localparam int DAS_F = 10;
    localparam int ARR_F = 3;
    localparam int SD_F  = 2;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    key_cmd_gen_if kif();

    key_cmd_gen #(
        .DAS_FRAMES   (DAS_F),
        .ARR_FRAMES   (ARR_F),
        .SDROP_FRAMES (SD_F)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .kif       (kif)
    );

    always #5 frame_clk = ~frame_clk;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         edge_n   = 0;
    int         press_e  = 0;
    int         rot_cnt  = 0;
    logic [7:0] held_key = 8'h00;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic recognised(input logic [7:0] kc);
        case (kc)
            8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C: return 1'b1;
`ifdef KEY_HOLD_EN
            8'h06: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Bits: 0 left, 1 right, 2 down, 3 rotate, 4 drop, 5 hold, 6 key_active.
    function automatic int key_bit(input logic [7:0] kc);
        case (kc)
            8'h04:   return 0;
            8'h07:   return 1;
            8'h16:   return 2;
            8'h1A:   return 3;
            8'h2C:   return 4;
            default: return 5;
        endcase
    endfunction

    // Pulse times follow from frames elapsed since the press edge.
    task automatic model_step(input logic rst, input logic [7:0] kc);
        logic [7:0] k;
        logic [7:0] v;
        logic       pulse;
        int         d;
        v = 8'h00;
        k = recognised(kc) ? kc : 8'h00;
        if (rst || k == 8'h00) begin
            held_key = 8'h00;
        end else begin
            if (k != held_key) begin
                held_key = k;
                press_e  = edge_n;
                pulse    = 1'b1;
            end else begin
                d = edge_n - press_e;
                if (k == 8'h04 || k == 8'h07)
                    pulse = (d == 0) || (d >= DAS_F && ((d - DAS_F) % ARR_F) == 0);
                else if (k == 8'h16)
                    pulse = (d % SD_F) == 0;
                else
                    pulse = (d == 0);
            end
            v[6] = 1'b1;
            if (pulse) v[key_bit(k)] = 1'b1;
        end
        exp_q.push_back(v);
    endtask

    function automatic logic [7:0] observed();
        logic [7:0] o;
        o = {1'b0, kif.key_active, 1'b0, kif.cmd_drop, kif.cmd_rotate,
             kif.cmd_down, kif.cmd_right, kif.cmd_left};
`ifdef KEY_HOLD_EN
        o[5] = kif.cmd_hold;
`endif
        return o;
    endfunction

    task automatic drive_frame(input string tag, input logic rst, input logic [7:0] kc);
        logic [7:0] got;
        @(negedge frame_clk);
        Reset       = rst;
        kif.keycode = kc;
        model_step(rst, kc);
        @(posedge frame_clk);
        #1;
        got = observed();
        if (got[3]) rot_cnt++;
        check_eq(tag, got, exp_q.pop_front());
        edge_n++;
    endtask

    task automatic hold_key(input string tag, input logic rst, input logic [7:0] kc, input int n);
        for (int i = 0; i < n; i++) drive_frame(tag, rst, kc);
    endtask

    initial begin
        logic [7:0] keys[8];
        logic [7:0] kc;
        int         idx;

        kif.keycode = 8'h00;

        hold_key("reset", 1'b1, 8'h00, 3);
        check_eq("reset_state", 8'(kif.dbg_state), 8'(IDLE));
        hold_key("t1_idle", 1'b0, 8'h00, 5);

        hold_key("t2_left_das", 1'b0, KEY_LEFT, 20);
        hold_key("t2_release", 1'b0, 8'h00, 2);

        hold_key("t3_down", 1'b0, KEY_DOWN, 7);
        hold_key("t3_release", 1'b0, 8'h00, 2);

        rot_cnt = 0;
        hold_key("t4_rotate", 1'b0, KEY_ROTATE, 30);
        hold_key("t4_gap", 1'b0, 8'h00, 1);
        hold_key("t4_repress", 1'b0, KEY_ROTATE, 5);
        check_eq("t4_rot_count", 8'(rot_cnt), 8'd2);
        hold_key("t4_release", 1'b0, 8'h00, 2);

        hold_key("t5_left", 1'b0, KEY_LEFT, 15);
        hold_key("t5_switch_right", 1'b0, KEY_RIGHT, 20);

        hold_key("t6_reset_mid", 1'b1, KEY_RIGHT, 2);
        hold_key("t6_after_reset", 1'b0, KEY_RIGHT, 5);
        hold_key("t6_release", 1'b0, 8'h00, 2);

        hold_key("t7_hold_key", 1'b0, KEY_HOLD, 5);
        hold_key("t7_drop", 1'b0, KEY_DROP, 4);
        hold_key("t7_unknown", 1'b0, 8'h55, 3);
        hold_key("t7_release", 1'b0, 8'h00, 2);

        keys = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h06, 8'h00};
        for (int s = 0; s < 80; s++) begin
            idx = $urandom_range(0, 7);
            kc  = (idx == 7) ? 8'($urandom_range(0, 255)) : keys[idx];
            if ($urandom_range(0, 19) == 0)
                hold_key("rand_reset", 1'b1, kc, $urandom_range(1, 3));
            else
                hold_key("rand", 1'b0, kc, $urandom_range(1, 25));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
